alu_arbiter: RTL

- Shares the single combinational `alu` between NUM_REQ requesters, each with a valid/ready request channel.
- Round-robin arbitration picks one requester and registers its operands and op_code. The operation is run through one `alu` instance and the result returns on a single shared response channel tagged with the requester ID.
- Sits between the execute-stage clients and the `alu` datapath; it is the only block that drives the `alu` inputs.

---
 rtl/definitions_pkg.sv | 21 ++
 rtl/alu.sv | 25 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/alu_arbiter.sv | 133 +++++++++++++
 4 files changed

// File: rtl/definitions_pkg.sv
// Shared ALU op codes, datapath width and arbiter FSM states.
package definitions;

    localparam int OP_W   = 3;
    localparam int DATA_W = 32;

    // Codes not listed here make the alu return zero.
    typedef enum logic [OP_W-1:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b110
    } op_code;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } arb_state_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU: AND, OR, ADD, SUB (modulo 2^32); other codes yield 0.
module alu
    import definitions::*;
(
    input  logic [OP_W-1:0]   op_i,
    input  logic [DATA_W-1:0] rs_i,
    input  logic [DATA_W-1:0] rt_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o
);

    always_comb begin
        result_o = '0;
        case (op_i)
            OP_AND:  result_o = rs_i & rt_i;
            OP_OR:   result_o = rs_i | rt_i;
            OP_ADD:  result_o = rs_i + rt_i;
            OP_SUB:  result_o = rs_i - rt_i;
            default: result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    int unsigned k;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        k     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = int'(ptr) + i;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            if (!any && req[k]) begin
                any      = 1'b1;
                grant[k] = 1'b1;
                idx      = k[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one alu among NUM_REQ requesters with a tagged response channel.
// Define ALU_ARB_OVF_EN to add the signed-overflow flag output rsp_ovf_o.
module alu_arbiter
    import definitions::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ*OP_W-1:0]   req_op_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_rs_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_rt_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [ID_W-1:0]           rsp_id_o,
    output logic [DATA_W-1:0]         rsp_result_o,
    output logic                      rsp_zero_o,
`ifdef ALU_ARB_OVF_EN
    output logic                      rsp_ovf_o,
`endif
    output logic                      busy_o
);

    arb_state_t               state, next_state;
    logic [ID_W-1:0]          rr_ptr, next_ptr;
    logic [ID_W-1:0]          id_q;
    logic [NUM_REQ-1:0]       grant;
    logic [ID_W-1:0]          grant_idx;
    logic                     grant_any;
    logic                     accept;

    logic [OP_W-1:0]          op_p0;
    logic signed [DATA_W-1:0] rs_p0, rt_p0;
    logic [DATA_W-1:0]        alu_result;
    logic                     alu_zero;

`ifdef ALU_ARB_OVF_EN
    function automatic logic signed_ovf(input logic [OP_W-1:0] op,
                                        input logic signed [DATA_W-1:0] a,
                                        input logic signed [DATA_W-1:0] b,
                                        input logic signed [DATA_W-1:0] r);
        case (op)
            OP_ADD:  return (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
            OP_SUB:  return (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
            default: return 1'b0;
        endcase
    endfunction
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req   (req_valid_i),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    alu u_alu (
        .op_i     (op_p0),
        .rs_i     (rs_p0),
        .rt_i     (rt_p0),
        .result_o (alu_result),
        .zero_o   (alu_zero)
    );

    always_comb begin
        next_state  = state;
        req_ready_o = '0;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                req_ready_o = grant;
                accept      = grant_any;
                if (grant_any) next_state = EXEC;
            end
            EXEC:    next_state = RESP;
            RESP:    if (rsp_ready_i) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign next_ptr = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    assign busy_o   = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            id_q         <= '0;
            rsp_valid_o  <= 1'b0;
            rsp_id_o     <= '0;
            rsp_result_o <= '0;
            rsp_zero_o   <= 1'b0;
`ifdef ALU_ARB_OVF_EN
            rsp_ovf_o    <= 1'b0;
`endif
        end else begin
            state <= next_state;
            if (accept) begin
                rr_ptr <= next_ptr;
                id_q   <= grant_idx;
            end
            // Stage 1: alu result captured into the response registers
            if (state == EXEC) begin
                rsp_valid_o  <= 1'b1;
                rsp_id_o     <= id_q;
                rsp_result_o <= alu_result;
                rsp_zero_o   <= alu_zero;
`ifdef ALU_ARB_OVF_EN
                rsp_ovf_o    <= signed_ovf(op_p0, rs_p0, rt_p0, alu_result);
`endif
            end else if (state == RESP && rsp_ready_i) begin
                rsp_valid_o  <= 1'b0;
            end
        end
    end

    // Stage 0: operands of the granted requester
    always_ff @(posedge clk) begin
        if (accept) begin
            op_p0 <= req_op_i[int'(grant_idx)*OP_W +: OP_W];
            rs_p0 <= req_rs_i[int'(grant_idx)*DATA_W +: DATA_W];
            rt_p0 <= req_rt_i[int'(grant_idx)*DATA_W +: DATA_W];
        end
    end

endmodule
